// File: rtl/write_resp_router_pkg.sv
// axi_resp_pkg: B-channel response codes shared by the write return path.
// Exports resp_t and RESP_ERR_BIT (set for SLVERR/DECERR).
package axi_resp_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam int RESP_ERR_BIT = 1;

endpackage

// File: rtl/write_resp_router_if.sv
// B-channel bundle: one downstream (M_AXI) port, two upstream (S00/S01).
// slave modport = router view; master modport = fabric/bench view.
interface write_resp_router_if;

  logic       M_AXI_bvalid;
  logic [1:0] M_AXI_bresp;
  logic       M_AXI_bready;

  logic       S00_AXI_bvalid;
  logic [1:0] S00_AXI_bresp;
  logic       S00_AXI_bready;

  logic       S01_AXI_bvalid;
  logic [1:0] S01_AXI_bresp;
  logic       S01_AXI_bready;

  modport slave (
    input  M_AXI_bvalid, M_AXI_bresp,
    output M_AXI_bready,
    output S00_AXI_bvalid, S00_AXI_bresp,
    input  S00_AXI_bready,
    output S01_AXI_bvalid, S01_AXI_bresp,
    input  S01_AXI_bready
  );

  modport master (
    output M_AXI_bvalid, M_AXI_bresp,
    input  M_AXI_bready,
    input  S00_AXI_bvalid, S00_AXI_bresp,
    output S00_AXI_bready,
    input  S01_AXI_bvalid, S01_AXI_bresp,
    output S01_AXI_bready
  );

endinterface

// File: rtl/write_resp_router_fifo.sv
// resp_order_fifo: sync FIFO of master indices in AW issue order.
// Ports: push/din, pop, head, full, empty, count; async active-low reset.
module resp_order_fifo #(
  parameter int W = 1,
  parameter int D = 4,
  localparam int AW = $clog2(D),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [D];
  logic [W-1:0]  mem_d [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_acc;
  logic          pop_acc;

  assign full  = (count_q == CW'(D));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // When full, a same-cycle pop frees the slot being written.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_acc) - CW'(pop_acc);
    if (push_acc) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/write_resp_router.sv
// write_resp_router: steers downstream B responses to the AW issuer.
// Ports: ACLK/ARESETN, AW_Push/AW_Master in, AW_Full,
// Outstanding_Count, Overflow_Err, Err_Count out; B channel via bus.
// Macro WR_RESP_ERR_CNT_EN builds the saturating error counter.
module write_resp_router
  import axi_resp_pkg::*;
#(
  parameter int Masters_Num       = 2,
  parameter int Masters_ID_Size   = $clog2(Masters_Num),
  parameter int Outstanding_Depth = 4,
  parameter int Err_Cnt_Width     = 8,
  localparam int CW = $clog2(Outstanding_Depth) + 1
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       AW_Push,
  input  logic [Masters_ID_Size-1:0] AW_Master,
  output logic                       AW_Full,
  output logic [CW-1:0]              Outstanding_Count,
  output logic                       Overflow_Err,
  output logic [Err_Cnt_Width-1:0]   Err_Count,
  write_resp_router_if.slave         bus
);

  logic [Masters_ID_Size-1:0] head;
  logic                       empty;
  logic                       full;
  logic                       pop;
  logic                       sel0;
  logic                       sel1;
  logic                       m_bready;
  logic                       s0_bvalid;
  logic                       s1_bvalid;
  logic                       ovf_q, ovf_d;

  assign pop = bus.M_AXI_bvalid & m_bready;

  resp_order_fifo #(
    .W (Masters_ID_Size),
    .D (Outstanding_Depth)
  ) u_fifo (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .push  (AW_Push),
    .din   (AW_Master),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (Outstanding_Count)
  );

  assign AW_Full = full;

  // Empty FIFO: nothing selected, so a stray response stalls.
  assign sel0 = ~empty & (head == Masters_ID_Size'(0));
  assign sel1 = ~empty & (head != Masters_ID_Size'(0));

  always_comb begin
    m_bready  = 1'b0;
    s0_bvalid = 1'b0;
    s1_bvalid = 1'b0;
    unique case (1'b1)
      sel0: begin
        s0_bvalid = bus.M_AXI_bvalid;
        m_bready  = bus.S00_AXI_bready;
      end
      sel1: begin
        s1_bvalid = bus.M_AXI_bvalid;
        m_bready  = bus.S01_AXI_bready;
      end
      default: ;
    endcase
  end

  assign bus.M_AXI_bready   = m_bready;
  assign bus.S00_AXI_bvalid = s0_bvalid;
  assign bus.S01_AXI_bvalid = s1_bvalid;

  // bresp is broadcast; held at OKAY while reset is asserted.
  assign bus.S00_AXI_bresp = ARESETN ? bus.M_AXI_bresp : OKAY;
  assign bus.S01_AXI_bresp = ARESETN ? bus.M_AXI_bresp : OKAY;

  assign ovf_d = ovf_q | (AW_Push & full & ~pop);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign Overflow_Err = ovf_q;

`ifdef WR_RESP_ERR_CNT_EN
  logic [Err_Cnt_Width-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (pop && bus.M_AXI_bresp[RESP_ERR_BIT] && (err_q != '1))
      err_d = err_q + 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) err_q <= '0;
    else          err_q <= err_d;
  end

  assign Err_Count = err_q;
`else
  assign Err_Count = '0;
`endif

endmodule

// File: tb/tb_write_resp_router.sv
// tb_write_resp_router: scoreboard bench for write_resp_router.
// Expected issuers queued on AW push, compared on each B response.
module tb_write_resp_router;
  import axi_resp_pkg::*;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       AW_Push = 1'b0;
  logic       AW_Master = 1'b0;
  logic       AW_Full;
  logic [2:0] Outstanding_Count;
  logic       Overflow_Err;
  logic [1:0] Err_Count;

  write_resp_router_if bif();

  always #5 ACLK = ~ACLK;

  write_resp_router #(
    .Masters_Num       (2),
    .Outstanding_Depth (4),
    .Err_Cnt_Width     (2)
  ) dut (
    .ACLK              (ACLK),
    .ARESETN           (ARESETN),
    .AW_Push           (AW_Push),
    .AW_Master         (AW_Master),
    .AW_Full           (AW_Full),
    .Outstanding_Count (Outstanding_Count),
    .Overflow_Err      (Overflow_Err),
    .Err_Count         (Err_Count),
    .bus               (bif)
  );

  int n_run = 0;
  int n_fail = 0;
  int sb_q[$];
  bit m_ovf = 1'b0;
  int m_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit push, input bit m, input bit bv,
                       input logic [1:0] rsp, input bit r0, input bit r1);
    AW_Push            = push;
    AW_Master          = m;
    bif.M_AXI_bvalid   = bv;
    bif.M_AXI_bresp    = rsp;
    bif.S00_AXI_bready = r0;
    bif.S01_AXI_bready = r1;
  endtask

  task automatic chk_rst();
    chk("rst_cnt", 32'(Outstanding_Count), 0);
    chk("rst_full", 32'(AW_Full), 0);
    chk("rst_ovf", 32'(Overflow_Err), 0);
    chk("rst_err", 32'(Err_Count), 0);
    chk("rst_mrdy", 32'(bif.M_AXI_bready), 0);
    chk("rst_v0", 32'(bif.S00_AXI_bvalid), 0);
    chk("rst_v1", 32'(bif.S01_AXI_bvalid), 0);
    chk("rst_r0", 32'(bif.S00_AXI_bresp), 0);
    chk("rst_r1", 32'(bif.S01_AXI_bresp), 0);
  endtask

  // One clock: drive, check at negedge against model, advance model.
  task automatic cyc(input bit push, input bit m, input bit bv,
                     input logic [1:0] rsp, input bit r0, input bit r1);
    bit hv;
    int h;
    bit ev0, ev1, erdy, pop, acc;
    drive(push, m, bv, rsp, r0, r1);
    @(negedge ACLK);
    hv   = (sb_q.size() > 0);
    h    = hv ? sb_q[0] : 0;
    ev0  = hv && (h == 0) && bv;
    ev1  = hv && (h == 1) && bv;
    erdy = hv && ((h == 0) ? r0 : r1);
    chk("s00_bvalid", 32'(bif.S00_AXI_bvalid), 32'(ev0));
    chk("s01_bvalid", 32'(bif.S01_AXI_bvalid), 32'(ev1));
    chk("m_bready", 32'(bif.M_AXI_bready), 32'(erdy));
    chk("s00_bresp", 32'(bif.S00_AXI_bresp), 32'(rsp));
    chk("s01_bresp", 32'(bif.S01_AXI_bresp), 32'(rsp));
    chk("count", 32'(Outstanding_Count), 32'(sb_q.size()));
    chk("full", 32'(AW_Full), 32'(sb_q.size() == 4));
    chk("ovf", 32'(Overflow_Err), 32'(m_ovf));
    chk("err_cnt", 32'(Err_Count), 32'(m_err));
    pop = bv && erdy;
    acc = push && ((sb_q.size() < 4) || pop);
    if (push && !acc) m_ovf = 1'b1;
    if (pop) begin
      void'(sb_q.pop_front());
`ifdef WR_RESP_ERR_CNT_EN
      if (rsp[RESP_ERR_BIT] && m_err < 3) m_err++;
`endif
    end
    if (acc) sb_q.push_back(int'(m));
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 2'b00, 0, 0);
  endtask

  logic [1:0] err_seq [5];

  initial begin
    err_seq = '{2'(OKAY), 2'(SLVERR), 2'(DECERR), 2'(SLVERR), 2'(SLVERR)};
    drive(0, 0, 1, 2'b11, 1, 1);
    #12;
    chk_rst();
    @(negedge ACLK);
    drive(0, 0, 0, 2'b00, 0, 0);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;

    // In-order routing 1,0,1
    cyc(1, 1, 0, 2'b00, 0, 0);
    cyc(1, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2'b00, 1, 1);
    idle();

    // Full, overflow, push+pop while full
    cyc(1, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 0, 2'b00, 0, 0);
    cyc(1, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 0, 2'b00, 0, 0);
    cyc(1, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 1, 2'b00, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 2'b00, 1, 1);
    idle();

    // Head S00 back-pressured, then a single pop
    cyc(1, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 2'b00, 0, 1);
    cyc(0, 0, 1, 2'b00, 1, 0);
    cyc(0, 0, 1, 2'b00, 0, 1);
    idle();

    // Response with empty FIFO stalls
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 2'b10, 1, 1);
    idle();

    // Error counting and saturation
    for (int i = 0; i < 5; i++) begin
      cyc(1, i[0], 0, 2'b00, 0, 0);
      cyc(0, 0, 1, err_seq[i], 1, 1);
    end
    idle();

    // Async reset with 3 outstanding
    cyc(1, 1, 0, 2'b00, 0, 0);
    cyc(1, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 0, 2'b00, 0, 0);
    drive(0, 0, 1, 2'b11, 1, 1);
    #1;
    ARESETN = 1'b0;
    #1;
    chk_rst();
    sb_q.delete();
    m_ovf = 1'b0;
    m_err = 0;
    @(negedge ACLK);
    drive(0, 0, 0, 2'b00, 0, 0);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    cyc(0, 0, 1, 2'b00, 1, 1);
    cyc(1, 0, 0, 2'b00, 0, 0);
    cyc(0, 0, 1, 2'b00, 1, 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/write_resp_router.md
# write_resp_router

Write-response (B channel) return path for the two-master AXI write interconnect. It records the issuing master of every write-address handshake the arbiter completes, in issue order, in an outstanding-order FIFO. It then steers each downstream B response back to the master at the FIFO head. It sits beside the write-address QoS arbiter and closes the loop that arbiter opens.

## Interface
Parameters:
- Masters_Num, 2, number of upstream masters (fixed routing for S00/S01)
- Masters_ID_Size, $clog2(Masters_Num), width of the master index
- Outstanding_Depth, 4, maximum outstanding writes; power of two, ≥2
- Err_Cnt_Width, 8, width of the error counter

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset; asynchronous, active-low
- AW_Push  in  1  AW handshake completed downstream this cycle
- AW_Master  in  Masters_ID_Size  index of the master that owns the pushed AW
- AW_Full  out  1  FIFO full; arbiter must not issue a new AW
- Outstanding_Count  out  $clog2(Outstanding_Depth)+1  entries in flight
- Overflow_Err  out  1  sticky: push attempted while full without pop
- M_AXI_bvalid  in  1  downstream response valid
- M_AXI_bresp  in  2  downstream response code
- M_AXI_bready  out  1  downstream ready
- S00_AXI_bvalid / S01_AXI_bvalid  out  1  upstream response valid
- S00_AXI_bresp / S01_AXI_bresp  out  2  upstream response code
- S00_AXI_bready / S01_AXI_bready  in  1  upstream ready
- Err_Count  out  Err_Cnt_Width  saturating error-response count

## Operation
- FIFO holds master indices. Write at wr_ptr on AW_Push; read at rd_ptr on B handshake. Pointers are $clog2(Depth) bits and wrap modulo Depth.
- Pop condition: M_AXI_bvalid & M_AXI_bready.
- Routing, when the FIFO is non-empty:
  - head = fifo[rd_ptr].
  - S<head>_AXI_bvalid = M_AXI_bvalid; the other master's bvalid = 0.
  - bresp is forwarded to both masters unconditionally.
  - M_AXI_bready = S<head>_AXI_bready.
- FIFO empty: M_AXI_bready = 0 and both upstream bvalid = 0. An unexpected response stalls; it is never dropped.
- Count update: count += push_accepted − pop.
- Push accept rule: a push is accepted when not full, or when full with a pop in the same cycle.
- Push while full without pop: entry ignored, Overflow_Err set to 1; it clears only on reset.
- Simultaneous push and pop when empty is impossible, because pop requires non-empty.

## Timing
- Reset values:
  - pointers and count 0; Outstanding_Count 0
  - AW_Full 0, Overflow_Err 0, Err_Count 0
  - M_AXI_bready 0, S00/S01 bvalid 0, bresp 2'b00
- FIFO state is registered. The routing path is combinational from the registered head, giving zero-cycle B pass-through.
- An entry pushed at edge N is routable from cycle N+1. There is no same-cycle bypass into an empty FIFO.
- AW_Full = (count == Outstanding_Depth), decoded from the registered count.
- Reset mid-operation:
  - all outstanding entries are discarded; outputs return to reset values asynchronously
  - the router does not track which upstream masters must also be reset

## Configuration
- Macro WR_RESP_ERR_CNT_EN.
- Defined:
  - Err_Count increments by 1 on each B handshake with M_AXI_bresp[1] = 1 (SLVERR or DECERR).
  - It saturates at all-ones and clears only on reset.
- Undefined: Err_Count is tied to '0 and the counter logic is not built.

## Structure
- Package axi_resp_pkg:
  - resp_t enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11
  - localparam RESP_ERR_BIT = 1
- Sub-module resp_order_fifo: parameterised width/depth sync FIFO with push, pop, head, full, empty and count. It is instantiated once.
- Top level holds the routing mux, overflow flag and optional counter.

## Test plan
- Reset, then push masters 1, 0, 1. Return 3 OKAY responses with bready high -> bvalid appears on S01, S00, S01 in order; Outstanding_Count goes 3→0.
- Push 4 entries -> AW_Full=1. A 5th push with no pop -> Overflow_Err=1 and count stays 4. Pop + push in the same cycle while full -> count stays 4 and the new entry is retained.
- Head = S00 with S00_AXI_bready=0 for 5 cycles while M_AXI_bvalid=1 -> M_AXI_bready=0 and no pop. Raising bready -> a single pop.
- M_AXI_bvalid=1 with the FIFO empty -> M_AXI_bready=0 and both upstream bvalid=0 indefinitely.
- With WR_RESP_ERR_CNT_EN and Err_Cnt_Width=2: send responses OKAY, SLVERR, DECERR, SLVERR, SLVERR -> Err_Count goes 0,1,2,3,3. With the macro undefined, Err_Count stays 0.
- Assert ARESETN low with 3 entries outstanding -> all outputs reach reset values without a clock edge; after release, routing restarts from an empty FIFO.
